mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameters (name, default, meaning): pc_size, 18, PC width; data_size, 32, datapath width; TIMEOUT, 255, maximum wait cycles per cache access.
REQ-002 clk  in  1  single clock; all state updates on the falling edge, matching the pipeline registers.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 M_MemtoReg, M_RegWrite, M_MemWrite, M_Jal, M_ExtendLH, M_ExtendSH  in  1 each  M-stage controls.
REQ-005 M_ALU_result, M_Rt_data  in  data_size  M-stage address or result, and store data.
REQ-006 M_PCplus8  in  pc_size; M_WR_out  in  5  destination register.
REQ-007 Pipe_hold  in  1  pipeline frozen by another unit, for example an I-cache miss.
REQ-008 DC_read, DC_write  out  1  data-cache request strobes; DC_addr  out  data_size  word-aligned address, low 2 bits zero.
REQ-009 DC_wdata  out  data_size; DC_byte_en  out  4; DC_rdata  in  data_size; DC_ready  in  1  access-complete indication.
REQ-010 M_stall  out  1  stall request that freezes the IF through EX/M stages.
REQ-011 Align_err, Bus_err  out  1 each  one-cycle error pulses.
REQ-012 WB_RegWrite  out  1; WB_WR_out  out  5; WB_data  out  data_size  registered M/WB outputs.

Function
REQ-013 Memory operation: mem_op = M_MemtoReg or M_MemWrite; a load has M_MemtoReg=1, and M_MemWrite takes priority if both are set.
REQ-014 Alignment rules:
- word access: M_ALU_result[1:0] must be 00;
- halfword access (ExtendLH or ExtendSH): bit 0 must be 0.
- A misaligned access never issues a cache request.
- It pulses Align_err for one cycle, sets WB_RegWrite=0 for that instruction and does not stall.
REQ-015 Store byte enables:
- word store: DC_byte_en=1111;
- halfword store: DC_byte_en=0011 when addr[1]=0, 1100 when addr[1]=1;
- halfword store data: DC_wdata carries M_Rt_data[15:0] replicated in both halves.
REQ-016 Halfword load: selects DC_rdata[15:0] when addr[1]=0, [31:16] when addr[1]=1, and sign-extends it to data_size.
REQ-017 State machine: IDLE, WAIT, DONE.
REQ-018 IDLE behaviour: on an aligned mem_op, assert DC_read or DC_write combinationally in the same cycle.
- DC_ready=1 in that cycle: complete with zero wait states.
- Otherwise: go to WAIT and assert M_stall.
REQ-019 WAIT behaviour:
- hold DC_addr, DC_wdata, DC_byte_en and the strobes stable;
- keep M_stall=1;
- count wait cycles in an 8-bit counter.
- DC_ready=1: complete.
- Counter reaches TIMEOUT: pulse Bus_err, drop the request, complete with WB_RegWrite=0.
REQ-020 Completion while Pipe_hold=1 enters DONE. DONE issues no requests and returns to IDLE when Pipe_hold=0, so a held instruction is never re-issued.
REQ-021 M_stall is 0 in IDLE and DONE, and in the completing cycle of a zero-wait access.
REQ-022 M/WB register, updated when M_stall=0 and Pipe_hold=0:
- WB_RegWrite = M_RegWrite, gated by the error rules above;
- WB_WR_out = M_WR_out;
- WB_data = zero-extended M_PCplus8 if M_Jal, else load data if a load, else M_ALU_result.
REQ-023 Bubble and hold behaviour of the M/WB register:
- while M_stall=1, the register loads a bubble (WB_RegWrite=0, WB_WR_out=0, WB_data=0);
- while Pipe_hold=1 and M_stall=0, it holds its value.
REQ-024 Load data used on completion is DC_rdata sampled in the DC_ready cycle, giving 1-edge latency from DC_ready to WB_data.
REQ-025 The wait counter clears on entry to WAIT and on completion.

Reset
REQ-026 On rst=1 at a falling edge, the block enters IDLE and clears the wait counter and all WB_* outputs to 0.
REQ-027 During reset, the DC strobes, M_stall, Align_err and Bus_err are 0.
REQ-028 Reset asserted during WAIT abandons the access with no Bus_err.

Structure
REQ-029 A shared package holds the state encoding (IDLE=0, WAIT=1, DONE=2), the TIMEOUT default and the byte-enable constants.
REQ-030 Load alignment and sign extension sit in one combinational sub-module, load_align.

Verification
REQ-031 Zero-wait load: lw from addr 0x10, DC_ready=1 in the same cycle, DC_rdata=0xDEADBEEF -> M_stall never high; next edge WB_data=0xDEADBEEF and WB_RegWrite=1.
REQ-032 Two-wait halfword load: lh from addr 0x22, DC_ready after 2 cycles, DC_rdata=0x8001_1234 -> M_stall high for 2 cycles, 2 bubbles in WB, then WB_data=0xFFFF8001.
REQ-033 Halfword store: sh to addr 0x40 with Rt=0x0000ABCD -> DC_write=1, DC_byte_en=0011, DC_wdata=0xABCDABCD.
REQ-034 Misaligned word load: lw from addr 0x13 -> no DC_read, Align_err pulses once, WB_RegWrite=0, M_stall=0.
REQ-035 Timeout: DC_ready held at 0 -> Bus_err pulses at wait cycle 255, M_stall drops, WB_RegWrite=0.
REQ-036 Hold and reset:
- store completes with Pipe_hold=1 held for 3 cycles -> exactly one DC_write cycle;
- rst during WAIT -> next edge in IDLE with all outputs 0.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: FSM encoding,
// wait-counter sizing and data-cache byte-enable patterns.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned WAIT_CNT_W      = 8;
  localparam int unsigned HALF_W          = 16;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  // Byte lanes written by a store of the given size at address bit 1.
  function automatic logic [3:0] store_be(input logic half, input logic hi);
    if (!half) return BE_WORD;
    return hi ? BE_HALF_HI : BE_HALF_LO;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data alignment: picks the addressed halfword and sign-extends it,
// or passes a full word through unchanged.
module load_align
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned data_size = 32
) (
  input  logic [data_size-1:0] rdata,
  input  logic                 half,
  input  logic                 hi,
  output logic [data_size-1:0] data_c
);

  logic [HALF_W-1:0] half_sel;

  always_comb begin
    half_sel = hi ? rdata[2*HALF_W-1:HALF_W] : rdata[HALF_W-1:0];
    data_c   = half ? {{(data_size-HALF_W){half_sel[HALF_W-1]}}, half_sel} : rdata;
  end

endmodule

// File: rtl/mem_access_stage.sv
// M stage of the pipeline: issues data-cache accesses, stalls upstream while
// the cache is busy, checks alignment/timeout and owns the M/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned pc_size   = 18,
  parameter int unsigned data_size = 32,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 M_MemtoReg,
  input  logic                 M_RegWrite,
  input  logic                 M_MemWrite,
  input  logic                 M_Jal,
  input  logic                 M_ExtendLH,
  input  logic                 M_ExtendSH,
  input  logic [data_size-1:0] M_ALU_result,
  input  logic [data_size-1:0] M_Rt_data,
  input  logic [pc_size-1:0]   M_PCplus8,
  input  logic [4:0]           M_WR_out,
  input  logic                 Pipe_hold,
  output logic                 DC_read,
  output logic                 DC_write,
  output logic [data_size-1:0] DC_addr,
  output logic [data_size-1:0] DC_wdata,
  output logic [3:0]           DC_byte_en,
  input  logic [data_size-1:0] DC_rdata,
  input  logic                 DC_ready,
  output logic                 M_stall,
  output logic                 Align_err,
  output logic                 Bus_err,
  output logic                 WB_RegWrite,
  output logic [4:0]           WB_WR_out,
  output logic [data_size-1:0] WB_data
);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  req_write_q, req_write_d;
  logic                  req_half_q, req_half_d;
  logic                  req_hi_q, req_hi_d;
  logic [data_size-1:0]  req_addr_q, req_addr_d;
  logic [data_size-1:0]  req_wdata_q, req_wdata_d;
  logic [3:0]            req_be_q, req_be_d;
  logic [data_size-1:0]  ld_hold_q, ld_hold_d;
  logic                  err_hold_q, err_hold_d;
  logic                  wb_regwrite_q, wb_regwrite_d;
  logic [4:0]            wb_wr_q, wb_wr_d;
  logic [data_size-1:0]  wb_data_q, wb_data_d;

  logic                  mem_op, is_store, is_load, is_half, misaligned;
  logic [data_size-1:0]  cur_addr, cur_wdata;
  logic [3:0]            cur_be;
  logic                  la_half, la_hi;
  logic [data_size-1:0]  la_data_c;
  logic                  rd_c, wr_c, stall_c, align_err_c, bus_err_c, complete_c;
  logic [data_size-1:0]  addr_c, wdata_c;
  logic [3:0]            be_c;
  logic                  ret_err;
  logic [data_size-1:0]  ret_ld;

  // Instruction decode and the request it would issue from IDLE.
  always_comb begin
    mem_op     = M_MemtoReg | M_MemWrite;
    is_store   = M_MemWrite;
    is_load    = M_MemtoReg & ~M_MemWrite;
    is_half    = M_ExtendLH | M_ExtendSH;
    misaligned = is_half ? M_ALU_result[0] : (M_ALU_result[1:0] != 2'b00);
    cur_addr   = {M_ALU_result[data_size-1:2], 2'b00};
    cur_be     = store_be(is_half, M_ALU_result[1]);
    cur_wdata  = is_half ? {(data_size/HALF_W){M_Rt_data[HALF_W-1:0]}} : M_Rt_data;
  end

  always_comb begin
    la_half = (state_q == WAIT) ? req_half_q : is_half;
    la_hi   = (state_q == WAIT) ? req_hi_q   : M_ALU_result[1];
  end

  load_align #(
    .data_size(data_size)
  ) u_load_align (
    .rdata (DC_rdata),
    .half  (la_half),
    .hi    (la_hi),
    .data_c(la_data_c)
  );

  // Access FSM; completion while held parks in DONE so nothing is re-issued.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_write_d = req_write_q;
    req_half_d  = req_half_q;
    req_hi_d    = req_hi_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    ld_hold_d   = ld_hold_q;
    err_hold_d  = err_hold_q;
    rd_c        = 1'b0;
    wr_c        = 1'b0;
    stall_c     = 1'b0;
    align_err_c = 1'b0;
    bus_err_c   = 1'b0;
    complete_c  = 1'b0;
    addr_c      = cur_addr;
    wdata_c     = cur_wdata;
    be_c        = cur_be;

    case (state_q)
      IDLE: begin
        if (mem_op && !misaligned) begin
          rd_c = ~is_store;
          wr_c = is_store;
          if (DC_ready) begin
            complete_c = 1'b1;
          end else begin
            stall_c     = 1'b1;
            state_d     = WAIT;
            cnt_d       = '0;
            req_write_d = is_store;
            req_half_d  = is_half;
            req_hi_d    = M_ALU_result[1];
            req_addr_d  = cur_addr;
            req_wdata_d = cur_wdata;
            req_be_d    = cur_be;
          end
        end else if (mem_op && !Pipe_hold) begin
          align_err_c = 1'b1;
        end
      end
      WAIT: begin
        addr_c  = req_addr_q;
        wdata_c = req_wdata_q;
        be_c    = req_be_q;
        if (DC_ready) begin
          rd_c       = ~req_write_q;
          wr_c       = req_write_q;
          complete_c = 1'b1;
        end else if (cnt_q == WAIT_CNT_W'(TIMEOUT)) begin
          bus_err_c  = 1'b1;
          complete_c = 1'b1;
        end else begin
          rd_c    = ~req_write_q;
          wr_c    = req_write_q;
          stall_c = 1'b1;
          cnt_d   = cnt_q + WAIT_CNT_W'(1);
        end
      end
      DONE: begin
        if (!Pipe_hold) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (complete_c) begin
      state_d    = Pipe_hold ? DONE : IDLE;
      cnt_d      = '0;
      ld_hold_d  = la_data_c;
      err_hold_d = bus_err_c;
    end
  end

  // M/WB register: bubble on stall, hold on external freeze, else retire.
  always_comb begin
    ret_err       = align_err_c | ((state_q == DONE) ? err_hold_q : bus_err_c);
    ret_ld        = (state_q == DONE) ? ld_hold_q : la_data_c;
    wb_regwrite_d = wb_regwrite_q;
    wb_wr_d       = wb_wr_q;
    wb_data_d     = wb_data_q;
    if (stall_c) begin
      wb_regwrite_d = 1'b0;
      wb_wr_d       = '0;
      wb_data_d     = '0;
    end else if (!Pipe_hold) begin
      wb_regwrite_d = M_RegWrite & ~ret_err;
      wb_wr_d       = M_WR_out;
      if (M_Jal)        wb_data_d = data_size'(M_PCplus8);
      else if (is_load) wb_data_d = ret_ld;
      else              wb_data_d = M_ALU_result;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_write_q   <= 1'b0;
      req_half_q    <= 1'b0;
      req_hi_q      <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      req_be_q      <= '0;
      ld_hold_q     <= '0;
      err_hold_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_wr_q       <= '0;
      wb_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_write_q   <= req_write_d;
      req_half_q    <= req_half_d;
      req_hi_q      <= req_hi_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      req_be_q      <= req_be_d;
      ld_hold_q     <= ld_hold_d;
      err_hold_q    <= err_hold_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_wr_q       <= wb_wr_d;
      wb_data_q     <= wb_data_d;
    end
  end

  // Strobes, stall and error pulses are forced low while reset is applied.
  assign DC_read     = rd_c & ~rst;
  assign DC_write    = wr_c & ~rst;
  assign M_stall     = stall_c & ~rst;
  assign Align_err   = align_err_c & ~rst;
  assign Bus_err     = bus_err_c & ~rst;
  assign DC_addr     = addr_c;
  assign DC_wdata    = wdata_c;
  assign DC_byte_en  = be_c;
  assign WB_RegWrite = wb_regwrite_q;
  assign WB_WR_out   = wb_wr_q;
  assign WB_data     = wb_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: the driver predicts every cycle from
// instruction-level rules and queues it; a monitor pops and compares.
module tb_mem_access_stage;

  localparam int unsigned PC_W = 18;
  localparam int unsigned DW   = 32;
  localparam int unsigned TMO  = 255;

  localparam int K_ALU = 0;
  localparam int K_JAL = 1;
  localparam int K_LW  = 2;
  localparam int K_LH  = 3;
  localparam int K_SW  = 4;
  localparam int K_SH  = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            M_MemtoReg, M_RegWrite, M_MemWrite, M_Jal, M_ExtendLH, M_ExtendSH;
  logic [DW-1:0]   M_ALU_result, M_Rt_data;
  logic [PC_W-1:0] M_PCplus8;
  logic [4:0]      M_WR_out;
  logic            Pipe_hold;
  logic            DC_read, DC_write;
  logic [DW-1:0]   DC_addr, DC_wdata, DC_rdata;
  logic [3:0]      DC_byte_en;
  logic            DC_ready;
  logic            M_stall, Align_err, Bus_err;
  logic            WB_RegWrite;
  logic [4:0]      WB_WR_out;
  logic [DW-1:0]   WB_data;

  mem_access_stage #(
    .pc_size  (PC_W),
    .data_size(DW),
    .TIMEOUT  (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .M_MemtoReg  (M_MemtoReg),
    .M_RegWrite  (M_RegWrite),
    .M_MemWrite  (M_MemWrite),
    .M_Jal       (M_Jal),
    .M_ExtendLH  (M_ExtendLH),
    .M_ExtendSH  (M_ExtendSH),
    .M_ALU_result(M_ALU_result),
    .M_Rt_data   (M_Rt_data),
    .M_PCplus8   (M_PCplus8),
    .M_WR_out    (M_WR_out),
    .Pipe_hold   (Pipe_hold),
    .DC_read     (DC_read),
    .DC_write    (DC_write),
    .DC_addr     (DC_addr),
    .DC_wdata    (DC_wdata),
    .DC_byte_en  (DC_byte_en),
    .DC_rdata    (DC_rdata),
    .DC_ready    (DC_ready),
    .M_stall     (M_stall),
    .Align_err   (Align_err),
    .Bus_err     (Bus_err),
    .WB_RegWrite (WB_RegWrite),
    .WB_WR_out   (WB_WR_out),
    .WB_data     (WB_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, rd, wr, aerr, berr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        wb_rw;
    logic [4:0]  wb_wr;
    logic [31:0] wb_data;
    logic        wb_chk;
  } exp_t;

  typedef struct {
    int          kind;
    logic        rw, both;
    logic [4:0]  wr;
    logic [31:0] alu, rt, rdata;
    logic [17:0] pc8;
  } ins_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic        m_rw   = 1'b0;
  logic [4:0]  m_wr   = '0;
  logic [31:0] m_data = '0;
  logic        m_chk  = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, want);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.stall = 0; e.rd = 0; e.wr = 0; e.aerr = 0; e.berr = 0;
    e.addr = '0; e.wdata = '0; e.be = '0;
    e.wb_rw = 0; e.wb_wr = '0; e.wb_data = '0; e.wb_chk = 1;
    return e;
  endfunction

  function automatic ins_t mk(input int kind, input logic [31:0] alu, input logic [31:0] rt,
                              input logic [31:0] rdata, input logic rw, input logic [4:0] wr);
    ins_t in;
    in.kind = kind; in.alu = alu; in.rt = rt; in.rdata = rdata;
    in.rw = rw; in.wr = wr; in.both = 1'b0; in.pc8 = 18'($urandom);
    return in;
  endfunction

  // One cycle: queue the prediction (with the M/WB state after this edge), then advance.
  task automatic step(input exp_t e, input bit upd, input logic rw, input logic [4:0] wr,
                      input logic [31:0] d, input bit dchk);
    if (upd) begin
      m_rw = rw; m_wr = wr; m_data = d; m_chk = dchk;
    end
    e.wb_rw = m_rw; e.wb_wr = m_wr; e.wb_data = m_data; e.wb_chk = m_chk;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input ins_t in);
    M_MemtoReg   = (in.kind == K_LW) || (in.kind == K_LH) || (in.kind == K_SW && in.both);
    M_MemWrite   = (in.kind == K_SW) || (in.kind == K_SH);
    M_ExtendLH   = (in.kind == K_LH);
    M_ExtendSH   = (in.kind == K_SH);
    M_Jal        = (in.kind == K_JAL);
    M_RegWrite   = in.rw;
    M_ALU_result = in.alu;
    M_Rt_data    = in.rt;
    M_PCplus8    = in.pc8;
    M_WR_out     = in.wr;
    DC_rdata     = in.rdata;
  endtask

  // Reference model: lat = cycles before DC_ready (-1 = never), hold = Pipe_hold cycles at completion.
  task automatic run_instr(input ins_t in, input int lat, input int hold);
    bit          is_st, is_ld, is_mem, is_half, mis, err;
    int          sh, n_wait;
    logic [31:0] half16, ld_val, res, wd, addr;
    logic [3:0]  be;
    exp_t        e, rq;
    is_st   = (in.kind == K_SW) || (in.kind == K_SH);
    is_ld   = (in.kind == K_LW) || (in.kind == K_LH);
    is_mem  = is_st || is_ld;
    is_half = (in.kind == K_LH) || (in.kind == K_SH);
    mis     = is_mem && (is_half ? (in.alu % 2 != 0) : (in.alu % 4 != 0));
    addr    = in.alu - (in.alu % 4);
    sh      = ((in.alu / 2) % 2 != 0) ? 16 : 0;
    half16  = (in.rdata >> sh) & 32'hFFFF;
    ld_val  = !is_half ? in.rdata : (half16 >= 32'h8000 ? half16 + 32'hFFFF0000 : half16);
    be      = !is_half ? 4'b1111 : (sh != 0 ? 4'b1100 : 4'b0011);
    wd      = is_half ? (in.rt & 32'hFFFF) * 32'h0001_0001 : in.rt;
    res     = (in.kind == K_JAL) ? 32'(in.pc8) : (is_ld ? ld_val : in.alu);
    drive(in);
    if (!is_mem || mis) begin
      for (int h = 0; h < hold; h++) begin
        Pipe_hold = 1'b1; DC_ready = 1'b0;
        step(zero_exp(), 0, 0, '0, '0, 1);
      end
      Pipe_hold = 1'b0; DC_ready = 1'b0;
      e = zero_exp(); e.aerr = mis;
      step(e, 1, in.rw && !mis, in.wr, res, !mis);
      return;
    end
    rq = zero_exp();
    rq.rd = !is_st; rq.wr = is_st; rq.addr = addr; rq.wdata = wd; rq.be = be;
    n_wait = (lat < 0) ? int'(TMO) + 1 : lat;
    for (int c = 0; c < n_wait; c++) begin
      Pipe_hold = 1'b0; DC_ready = 1'b0;
      e = rq; e.stall = 1'b1;
      step(e, 1, 1'b0, '0, '0, 1);
    end
    err = (lat < 0);
    Pipe_hold = (hold > 0); DC_ready = !err;
    e = err ? zero_exp() : rq;
    e.berr = err;
    step(e, hold == 0, in.rw && !err, in.wr, res, !err);
    if (hold > 0) begin
      for (int h = 1; h < hold; h++) begin
        Pipe_hold = 1'b1; DC_ready = 1'b0;
        step(zero_exp(), 0, 0, '0, '0, 1);
      end
      Pipe_hold = 1'b0; DC_ready = 1'b0;
      step(zero_exp(), 1, in.rw && !err, in.wr, res, !err);
    end
  endtask

  // Monitor: combinational outputs mid-cycle, M/WB outputs one edge later.
  initial begin
    exp_t prev, e;
    bit   have_prev;
    have_prev = 0;
    forever begin
      @(posedge clk);
      if (have_prev) begin
        chk("wb_ctl", 32'({WB_RegWrite, WB_WR_out}), 32'({prev.wb_rw, prev.wb_wr}));
        if (prev.wb_chk) chk("wb_data", WB_data, prev.wb_data);
      end
      if (exp_q.size() == 0) begin
        have_prev = 0;
      end else begin
        e = exp_q.pop_front();
        chk("ctl{stall,rd,wr,aerr,berr}",
            32'({M_stall, DC_read, DC_write, Align_err, Bus_err}),
            32'({e.stall, e.rd, e.wr, e.aerr, e.berr}));
        if (e.rd || e.wr) chk("dc_addr", DC_addr, e.addr);
        if (e.wr) begin
          chk("dc_wdata", DC_wdata, e.wdata);
          chk("dc_byte_en", 32'(DC_byte_en), 32'(e.be));
        end
        prev = e;
        have_prev = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t in;
    exp_t e;
    int   lat, hold;
    rst = 1'b1; Pipe_hold = 1'b0; DC_ready = 1'b1;
    drive(mk(K_LW, 32'h10, 32'h0, 32'h1234_5678, 1'b1, 5'd3));
    step(zero_exp(), 1, 1'b0, '0, '0, 1);
    step(zero_exp(), 1, 1'b0, '0, '0, 1);
    rst = 1'b0;

    run_instr(mk(K_LW, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b1, 5'd5), 0, 0);
    run_instr(mk(K_LH, 32'h22, 32'h0, 32'h8001_1234, 1'b1, 5'd6), 2, 0);
    run_instr(mk(K_SH, 32'h40, 32'h0000_ABCD, 32'h0, 1'b0, 5'd0), 0, 0);
    run_instr(mk(K_LW, 32'h13, 32'h0, 32'hCAFE_F00D, 1'b1, 5'd7), 0, 0);
    run_instr(mk(K_JAL, 32'h5555, 32'h0, 32'h0, 1'b1, 5'd31), 0, 1);
    run_instr(mk(K_LW, 32'h200, 32'h0, 32'h1111_2222, 1'b1, 5'd8), -1, 0);
    run_instr(mk(K_SW, 32'h300, 32'h7777_8888, 32'h0, 1'b0, 5'd0), 0, 3);
    run_instr(mk(K_LH, 32'h46, 32'h0, 32'h7FFF_0123, 1'b1, 5'd9), 1, 2);
    run_instr(mk(K_ALU, 32'hA5A5_0001, 32'h0, 32'h0, 1'b1, 5'd10), 0, 0);

    // Reset in the middle of a waited load abandons it silently.
    drive(mk(K_LW, 32'h100, 32'h0, 32'h0, 1'b1, 5'd11));
    Pipe_hold = 1'b0; DC_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      e = zero_exp(); e.stall = 1; e.rd = 1; e.addr = 32'h100;
      step(e, 1, 1'b0, '0, '0, 1);
    end
    rst = 1'b1;
    step(zero_exp(), 1, 1'b0, '0, '0, 1);
    rst = 1'b0;
    run_instr(mk(K_LW, 32'h104, 32'h0, 32'h0BAD_CAFE, 1'b1, 5'd12), 0, 0);

    for (int n = 0; n < 150; n++) begin
      in = mk($urandom_range(0, 5), $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom));
      in.both = 1'($urandom);
      if ($urandom_range(0, 3) != 0) in.alu = in.alu & 32'hFFFF_FFFC;
      lat  = $urandom_range(0, 3);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_instr(in, lat, hold);
    end
    run_instr(mk(K_ALU, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0), 0, 0);

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
